// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED blink path: divisor width and limits,
// the one-second tick count used by the blink counter, the per-button
// FSM state type, and the wrapping divisor step helper.
package led_pkg;

  localparam int             DIV_W   = 5;
  localparam logic [DIV_W-1:0] DIV_MIN = 5'd1;
  localparam logic [DIV_W-1:0] DIV_MAX = 5'h14;
  localparam logic [27:0]    CNT_1S  = 28'h5F5E100;

  typedef enum logic [1:0] {IDLE, HOLD, RPT} btn_st_t;

  // One divisor step with wrap-around at both limits, so the result never
  // leaves DIV_MIN..DIV_MAX (the blink counter treats 0 and >20 as 1 Hz).
  function automatic logic [DIV_W-1:0] divStep(input logic [DIV_W-1:0] cur,
                                               input logic up);
    if (up) begin
      return (cur == DIV_MAX) ? DIV_MIN : cur + 5'd1;
    end
    return (cur == DIV_MIN) ? DIV_MAX : cur - 5'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes one raw asynchronous active-high button into clk100 and
// debounces it. The debounced level only changes after the synced input
// has disagreed with it for DEBOUNCE_CYC consecutive cycles.
// Ports:
//   clk100  - 100 MHz clock
//   rst     - synchronous active-high reset
//   btn_i   - raw button, asynchronous
//   db_o    - debounced level
//   press_o - one-cycle pulse, coincident with the first cycle db_o is high
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn_i,
  output logic db_o,
  output logic press_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the debounced level
  // restarts the count. The press pulse is produced here, together with the
  // level change, so the downstream FSM sees it the same cycle db goes high.
  always_comb begin
    db_d    = db_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Two-flop synchronizer followed by the debounce state registers.
  always_ff @(posedge clk100) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/led_div_ctrl.sv
// led_div_ctrl
// Pushbutton front-end for the LED blink counter. Two debounced buttons
// step a blink divisor up/down with wrap-around and auto-repeat; pressing
// both (chord) restores DIV_RST. Every accepted change pulses wren_o once.
// Ports:
//   clk100   - 100 MHz clock
//   rst      - synchronous active-high reset
//   btn_up_i - raw up button, asynchronous, active-high
//   btn_dn_i - raw down button, asynchronous, active-high
//   div_o    - current divisor, registered, always DIV_MIN..DIV_MAX
//   wren_o   - one-cycle strobe in the first cycle div_o holds a new value
//   busy_o   - high while either debounced button level is high
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int DIV_RST      = 5
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             busy_o
);

  localparam int               TMR_MAX   = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
  localparam int               TMR_W     = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REPEAT_DLY - 1);
  localparam logic [TMR_W-1:0] CYC_LAST  = TMR_W'(REPEAT_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0]       db;
  logic [1:0]       press;
  btn_st_t          st_q  [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [1:0]       pressReq, rptReq;
  logic             chord, stepUp, stepDn;
  logic             actUp_q, actDn_q, actChord_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wren_q, wren_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uDbUp (
    .clk100 (clk100),
    .rst    (rst),
    .btn_i  (btn_up_i),
    .db_o   (db[0]),
    .press_o(press[0])
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uDbDn (
    .clk100 (clk100),
    .rst    (rst),
    .btn_i  (btn_dn_i),
    .db_o   (db[1]),
    .press_o(press[1])
  );

  // Step requests and their classification. A press always implies its own
  // db is high, so "press while the other db is high" also covers two
  // presses landing in the same cycle. Repeats while the other button is
  // held are simply not turned into steps.
  always_comb begin
    pressReq = '0;
    rptReq   = '0;
    for (int b = 0; b < 2; b++) begin
      pressReq[b] = (st_q[b] == IDLE) && press[b];
      rptReq[b]   = db[b] && (((st_q[b] == HOLD) && (tmr_q[b] == DLY_LAST)) ||
                              ((st_q[b] == RPT)  && (tmr_q[b] == CYC_LAST)));
    end
    chord  = (pressReq[0] && db[1]) || (pressReq[1] && db[0]);
    stepUp = (pressReq[0] || rptReq[0]) && !db[1];
    stepDn = (pressReq[1] || rptReq[1]) && !db[0];
  end

  // Per-button IDLE/HOLD/RPT FSMs with their repeat timers, plus the
  // registered arbitration decision. Dropping db returns a button to IDLE
  // without ever producing a step, so a release never changes the divisor.
  always_ff @(posedge clk100) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= IDLE;
        tmr_q[b] <= '0;
      end
      actUp_q    <= 1'b0;
      actDn_q    <= 1'b0;
      actChord_q <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!db[b]) begin
          st_q[b]  <= IDLE;
          tmr_q[b] <= '0;
        end else begin
          case (st_q[b])
            IDLE: begin
              tmr_q[b] <= '0;
              if (press[b]) begin
                st_q[b] <= HOLD;
              end
            end
            HOLD: begin
              if (tmr_q[b] == DLY_LAST) begin
                st_q[b]  <= RPT;
                tmr_q[b] <= '0;
              end else begin
                tmr_q[b] <= tmr_q[b] + 1'b1;
              end
            end
            RPT: begin
              if (tmr_q[b] == CYC_LAST) begin
                tmr_q[b] <= '0;
              end else begin
                tmr_q[b] <= tmr_q[b] + 1'b1;
              end
            end
            default: begin
              st_q[b]  <= IDLE;
              tmr_q[b] <= '0;
            end
          endcase
        end
      end
      actUp_q    <= stepUp;
      actDn_q    <= stepDn;
      actChord_q <= chord;
    end
  end

  // Divisor update. A chord wins over any single-button step and strobes
  // even if the divisor already equals DIV_RST.
  always_comb begin
    div_d  = div_q;
    wren_d = 1'b0;
    if (actChord_q) begin
      div_d  = DIV_RST_V;
      wren_d = 1'b1;
    end else if (actUp_q) begin
      div_d  = divStep(div_q, 1'b1);
      wren_d = 1'b1;
    end else if (actDn_q) begin
      div_d  = divStep(div_q, 1'b0);
      wren_d = 1'b1;
    end
  end

  // Output registers; reset leaves the strobe low so reset exit is silent.
  always_ff @(posedge clk100) begin
    if (rst) begin
      div_q  <= DIV_RST_V;
      wren_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wren_q <= wren_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign busy_o = |db;

endmodule
